mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/mem_lane.sv | 59 +++++
 rtl/mem_access.sv | 170 +++++++++++++++++
 tb/tb_mem_access.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_access load/store unit.
// Holds the access-size encoding, the FSM state encoding and the helper
// functions that decide legality, splitting and lane masks.
// Build option MEM_MISALIGN_EN: when defined, a misaligned half or word
// access becomes a two-beat split access. When it is undefined, such an
// access is rejected as illegal.
package mem_pkg;

  localparam int WORD_BYTES = 4;

`ifdef MEM_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  // Access size as encoded on the size port.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Right-aligned byte mask for an access size. The reserved size gives no bytes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // The access crosses a word boundary and needs a second bus beat.
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && (off == 2'b11)) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  // The access may start. A split access is legal only when splitting is built in.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    return (size != SZ_RSVD) && (MISALIGN_EN || !is_split(size, off));
  endfunction

  // Expand byte enables to a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational lane steering for mem_access.
// Places right-aligned store data onto byte lanes and generates the byte
// enables for the current beat. It also extracts the load result from the
// one or two captured bus words and applies zero or sign extension.
// "second" selects the upper half of the two-word window, which is the
// ACC2 beat of a split access.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic        second,
  input  logic [31:0] store_data,
  input  logic [31:0] load_lo,
  input  logic [23:0] load_hi,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [2*WORD_BYTES-1:0] be_wide;
  logic [63:0]             wdata_wide;
  logic [31:0]             aligned;
  logic [4:0]              shamt;

  assign shamt = {off, 3'b000};

  // Byte enables and lane data across a two-word window, then pick this beat's half.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    be_wide    = {4'b0000, size_mask(size)} << off;
    wdata_wide = {32'h0000_0000, store_data} << shamt;
    be         = second ? be_wide[7:4] : be_wide[3:0];
    lane_wdata = second ? wdata_wide[63:32] : wdata_wide[31:0];
  end

  // Right-align the addressed bytes. The upper word supplies the bytes that overflow.
  always_comb begin
    aligned = load_lo;
    case (off)
      2'd1:    aligned = {load_hi[7:0],  load_lo[31:8]};
      2'd2:    aligned = {load_hi[15:0], load_lo[31:16]};
      2'd3:    aligned = {load_hi[23:0], load_lo[31:24]};
      default: aligned = load_lo;
    endcase
  end

  // Zero- or sign-extend byte and half loads. Word loads pass through untouched.
  always_comb begin
    load_data = aligned;
    case (size)
      SZ_BYTE: load_data = {{24{signed_ld & aligned[7]}},  aligned[7:0]};
      SZ_HALF: load_data = {{16{signed_ld & aligned[15]}}, aligned[15:0]};
      default: load_data = aligned;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M-stage load/store unit. Sequences one or two bus beats per access.
// The request is latched on leaving IDLE. The unit stalls the pipeline until
// DONE and returns a registered, extended load result.
// An illegal access produces a one-cycle fault and no bus traffic.
// Build option MEM_MISALIGN_EN: adds the ACC2 beat for misaligned half/word
// accesses. Without it those accesses fault and no ACC2 logic is built.
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;

  // Request captured when the access starts. These registers keep the bus stable.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sgn_q;

  logic        flt_q;       // the fault was reported last cycle
  logic [31:0] rdata_q;

  logic        legal;
  logic        start;
  logic        fault_now;
  logic        in_acc;
  logic        last_ack;
  logic        second;
  logic [31:0] word_addr;
  logic [31:0] beat_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_lo;
  logic [23:0] load_hi;
  logic [31:0] load_data;

  assign legal     = is_legal(size, addr[1:0]);
  assign start     = (state_q == ST_IDLE) && req && legal;
  assign fault_now = (state_q == ST_IDLE) && req && !legal && !flt_q;
  assign word_addr = {addr_q[31:2], 2'b00};

`ifdef MEM_MISALIGN_EN
  logic [31:0] rbuf_q;      // ACC1 bytes of a split load, held until the ACC2 ack

  assign in_acc    = (state_q == ST_ACC1) || (state_q == ST_ACC2);
  assign second    = (state_q == ST_ACC2);
  assign beat_addr = second ? word_addr + 32'(WORD_BYTES) : word_addr;
  assign last_ack  = bus_ack && (((state_q == ST_ACC1) && !is_split(size_q, addr_q[1:0])) ||
                                  (state_q == ST_ACC2));
  assign load_lo   = second ? rbuf_q : bus_rdata;
  assign load_hi   = bus_rdata[23:0];

  // Capture the enabled lanes of the first beat of a split load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbuf_q <= 32'h0000_0000;
    end else if ((state_q == ST_ACC1) && bus_ack) begin
      rbuf_q <= bus_rdata & lane_mask(lane_be);
    end
  end
`else
  assign in_acc    = (state_q == ST_ACC1);
  assign second    = 1'b0;
  assign beat_addr = word_addr;
  assign last_ack  = bus_ack && (state_q == ST_ACC1);
  assign load_lo   = bus_rdata;
  assign load_hi   = 24'h00_0000;
`endif

  mem_lane u_lane (
    .off        (addr_q[1:0]),
    .size       (size_q),
    .signed_ld  (sgn_q),
    .second     (second),
    .store_data (wdata_q),
    .load_lo    (load_lo),
    .load_hi    (load_hi),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // Next-state logic. An ack outside the access states has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ACC1;
      ST_ACC1: begin
        if (bus_ack) begin
`ifdef MEM_MISALIGN_EN
          state_d = is_split(size_q, addr_q[1:0]) ? ST_ACC2 : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MEM_MISALIGN_EN
      ST_ACC2: if (bus_ack) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, request latch and fault-reported flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= ST_IDLE;
      flt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flt_q   <= fault_now;
      if (start) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= size;
        sgn_q   <= signed_ld;
      end
    end
  end

  // Load result register. It updates on the final ack of a load and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0000_0000;
    end else if (last_ack && !we_q) begin
      rdata_q <= load_data;
    end
  end

  // Bus outputs are driven only while a beat is in flight and are zero otherwise.
  assign bus_req   = in_acc;
  assign bus_we    = in_acc & we_q;
  assign bus_addr  = in_acc ? beat_addr  : 32'h0000_0000;
  assign bus_be    = in_acc ? lane_be    : 4'b0000;
  assign bus_wdata = in_acc ? lane_wdata : 32'h0000_0000;

  // Pipeline handshake. Reset forces these low even while req is high.
  // The cycle after a fault releases the stall, as DONE does.
  assign stall = rst & req & (state_q != ST_DONE) & ~flt_q;
  assign fault = rst & fault_now;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access. Expected bus beats and load results are
// queued when an access is set up and popped as the DUT produces them.
// Split-access cases are selected by MEM_MISALIGN_EN, matching the DUT build.
module tb_mem_access;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZR = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;   // expected lane data, enabled lanes only
    logic [31:0] rword;   // word returned by the bus for this beat
  } phase_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  phase_t      phase_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd;
  int          checks;
  int          errors;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .signed_ld (signed_ld),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_phase(input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] rw);
    phase_t p;
    p.addr  = a;
    p.be    = be;
    p.wdata = wd;
    p.rword = rw;
    phase_q.push_back(p);
  endtask

  task automatic expect_load(input logic [31:0] v);
    rd_q.push_back(v);
    last_rd = v;
  endtask

  task automatic expect_store();
    rd_q.push_back(last_rd);
  endtask

  // One access, starting at a negedge. The bus model acks each queued beat after dly wait cycles.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg, input int dly);
    phase_t p;
    int     guard;
    req = 1'b1; we = w; addr = a; wdata = wd; size = sz; signed_ld = sg;
    #1;
    check("stall_idle", 32'(stall), 32'd1);
    check("fault_legal", 32'(fault), 32'd0);
    while (phase_q.size() > 0) begin
      p = phase_q.pop_front();
      guard = 0;
      do begin
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        guard++;
      end while (!bus_req && guard < 4);
      check("bus_req_latency", 32'(guard), 32'd1);
      check("bus_req", 32'(bus_req), 32'd1);
      check("bus_addr", bus_addr, p.addr);
      check("bus_be", 32'(bus_be), 32'(p.be));
      check("bus_we", 32'(bus_we), 32'(w));
      if (w) check("bus_wdata", bus_wdata & lane_mask(p.be), p.wdata);
      for (int i = 0; i < dly; i++) begin
        addr = ~a; wdata = ~wd; size = ~sz; we = ~w; signed_ld = ~sg;
        @(negedge clk);
        check("hold_req", 32'(bus_req), 32'd1);
        check("hold_addr", bus_addr, p.addr);
        check("hold_be", 32'(bus_be), 32'(p.be));
        check("hold_we", 32'(bus_we), 32'(w));
        if (w) check("hold_wdata", bus_wdata & lane_mask(p.be), p.wdata);
        check("stall_wait", 32'(stall), 32'd1);
      end
      addr = a; wdata = wd; size = sz; we = w; signed_ld = sg;
      bus_ack = 1'b1;
      bus_rdata = p.rword;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    check("stall_done", 32'(stall), 32'd0);
    check("bus_req_done", 32'(bus_req), 32'd0);
    check("fault_done", 32'(fault), 32'd0);
    if (rd_q.size() > 0) check("rdata", rdata, rd_q.pop_front());
    else check("rdata_scoreboard_empty", 32'(rd_q.size()), 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("rdata_held", rdata, last_rd);
  endtask

  // An access the DUT must refuse: a one-cycle fault, no bus beat, then the stall releases.
  task automatic do_illegal(input logic [31:0] a, input logic [1:0] sz);
    req = 1'b1; we = 1'b0; addr = a; wdata = 32'h0; size = sz; signed_ld = 1'b1;
    #1;
    check("fault_pulse", 32'(fault), 32'd1);
    check("illegal_no_bus", 32'(bus_req), 32'd0);
    check("illegal_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("fault_one_cycle", 32'(fault), 32'd0);
    check("illegal_release", 32'(stall), 32'd0);
    check("illegal_no_bus2", 32'(bus_req), 32'd0);
    check("illegal_rdata", rdata, last_rd);
    req = 1'b0;
    @(negedge clk);
    check("illegal_idle_bus", 32'(bus_req), 32'd0);
    check("illegal_idle_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_rd = 32'h0;
    rst = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h40; wdata = 32'h0; size = SZR; signed_ld = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;

    // Reset state: outputs stay low even with an illegal request pending.
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);

    // Aligned word store with one wait cycle.
    expect_phase(32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    expect_store();
    do_access(1'b1, 32'h100, 32'hDEADBEEF, SZW, 1'b0, 1);

    // Signed byte load from lane 3 with an ack in the first ACC1 cycle (minimum latency).
    expect_phase(32'h100, 4'b1000, 32'h0, 32'h80112233);
    expect_load(32'hFFFFFF80);
    do_access(1'b0, 32'h103, 32'h0, SZB, 1'b1, 0);

    // Unsigned half load from the upper lanes.
    expect_phase(32'h100, 4'b1100, 32'h0, 32'h80112233);
    expect_load(32'h00008011);
    do_access(1'b0, 32'h102, 32'h0, SZH, 1'b0, 0);

    // Signed half load from the lower lanes, with waits and input churn.
    expect_phase(32'h200, 4'b0011, 32'h0, 32'h1234F00D);
    expect_load(32'hFFFFF00D);
    do_access(1'b0, 32'h200, 32'h0, SZH, 1'b1, 2);

    // Unsigned byte load from lane 1.
    expect_phase(32'h100, 4'b0010, 32'h0, 32'h80112233);
    expect_load(32'h00000022);
    do_access(1'b0, 32'h101, 32'h0, SZB, 1'b0, 0);

    // A word load ignores signed_ld.
    expect_phase(32'h10, 4'b1111, 32'h0, 32'h80000001);
    expect_load(32'h80000001);
    do_access(1'b0, 32'h10, 32'h0, SZW, 1'b1, 0);

    // Byte and half stores go to their lanes and leave rdata alone.
    expect_phase(32'h100, 4'b0100, 32'h00A50000, 32'h0);
    expect_store();
    do_access(1'b1, 32'h102, 32'h000000A5, SZB, 1'b0, 0);
    expect_phase(32'h20, 4'b1100, 32'hBEEF0000, 32'h0);
    expect_store();
    do_access(1'b1, 32'h22, 32'h0000BEEF, SZH, 1'b0, 1);

    // An ack while idle is ignored.
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ack_bus_req", 32'(bus_req), 32'd0);
    check("idle_ack_rdata", rdata, last_rd);
    check("idle_ack_stall", 32'(stall), 32'd0);
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);

    // The reserved size is illegal.
    do_illegal(32'h40, SZR);

`ifdef MEM_MISALIGN_EN
    // Split word load across 0x1FC/0x200.
    expect_phase(32'h1FC, 4'b1100, 32'h0, 32'hAABBCCDD);
    expect_phase(32'h200, 4'b0011, 32'h0, 32'h11223344);
    expect_load(32'h3344AABB);
    do_access(1'b0, 32'h1FE, 32'h0, SZW, 1'b0, 1);

    // Split signed half load at offset 3.
    expect_phase(32'h1000, 4'b1000, 32'h0, 32'hC0FFEE12);
    expect_phase(32'h1004, 4'b0001, 32'h0, 32'h000000F1);
    expect_load(32'hFFFFF1C0);
    do_access(1'b0, 32'h1003, 32'h0, SZH, 1'b1, 0);

    // Split word store wrapping from the top of memory to address 0.
    expect_phase(32'hFFFFFFFC, 4'b1000, 32'h44000000, 32'h0);
    expect_phase(32'h00000000, 4'b0111, 32'h00112233, 32'h0);
    expect_store();
    do_access(1'b1, 32'hFFFFFFFF, 32'h11223344, SZW, 1'b0, 1);
`else
    // Without split support, misaligned half and word accesses fault.
    do_illegal(32'h3, SZH);
    do_illegal(32'h102, SZW);
`endif

    // Reset while ACC1 is waiting for its ack. The late ack must be ignored.
    req = 1'b1; we = 1'b0; addr = 32'h300; wdata = 32'h0; size = SZW; signed_ld = 1'b0;
    @(negedge clk);
    check("rst_mid_bus_req_before", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_bus_addr", bus_addr, 32'h0);
    check("rst_mid_bus_be", 32'(bus_be), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_fault", 32'(fault), 32'd0);
    check("rst_mid_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h12345678;
    last_rd = 32'h0;
    @(negedge clk);
    check("late_ack_bus_req", 32'(bus_req), 32'd0);
    check("late_ack_rdata", rdata, 32'h0);
    check("late_ack_stall", 32'(stall), 32'd0);
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);

    // The unit works normally after the abandoned access.
    expect_phase(32'h100, 4'b0010, 32'h0, 32'h0000A700);
    expect_load(32'h000000A7);
    do_access(1'b0, 32'h101, 32'h0, SZB, 1'b0, 0);

    check("scoreboard_drained", 32'(rd_q.size() + phase_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
